approx_mul_pipe: RTL and testbench
==================================

Name: approx_mul_pipe

Overview:
- Parametrised, pipelined unsigned W x W multiplier with a per-operation approximation mode.
- Partial-product rows are compressed pairwise: exact half-adders in high columns, OR-sum or truncation in the low APPROX_COLS columns.
- The pair results are summed in a registered adder stage.
- Sits in the approximate-arithmetic datapath as the streaming successor of the fixed 8x8 half-adder-array generators, with a valid/ready handshake.

Parameters:
- W, 8, operand width; even, 4..16.
- APPROX_COLS, 4, number of low product columns (weights 0..APPROX_COLS-1) that receive approximate treatment; 0..2W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_x  in  W  multiplicand (row selector).
- in_y  in  W  multiplier.
- in_mode  in  2  00 exact, 01 OR-low, 10 truncate-low, 11 reserved (behaves as 00).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_p  out  2W  product.
- out_mode  out  2  mode the result was computed with (11 passed through unchanged).

Behaviour:
- Reset (async, immediate): all valid bits 0, out_p 0, out_mode 00, internal stage registers 0. in_ready is 1 after reset.
- Pipeline advance enable: en = ~out_valid | out_ready. in_ready = en (combinational from out_valid and out_ready).
- Beat accepted when in_valid & in_ready.
- Stage 1 (on en): register W/2 pair results, mode, and valid s1_v = in_valid.
- Stage 2 (on en): register out_p = sum of the pair results, out_mode, and out_valid = s1_v.
- Latency: exactly 2 cycles from accept to out_valid when there is no stall. Throughput: 1 per cycle.
- Bubbles are not collapsed. While stalled (en = 0), all stage registers hold and out_p/out_mode stay stable.
- Pair arithmetic, for k in 0..W/2-1:
  - A = (x[2k] ? y : 0) << 2k; B = (x[2k+1] ? y : 0) << (2k+1). Both 2W bits.
  - M = (1 << APPROX_COLS) - 1.
  - Exact mode: P_k = A + B.
  - OR-low mode: P_k = ((A & M) | (B & M)) + (A & ~M) + (B & ~M). The low-region carry is dropped.
  - Truncate mode: P_k = (A & ~M) + (B & ~M).
- out_p = sum of P_k, mod 2^(2W). No overflow is possible in exact mode.
- APPROX_COLS = 0: all modes equal exact.
- Approximate results are never greater than the exact product.
- Simultaneous stall and new input: the input is not accepted (in_ready = 0). Upstream must hold the beat.
- Reset mid-operation: in-flight beats are discarded; no spurious out_valid after release.
- Data on in_x/in_y/in_mode is ignored when in_valid = 0; the stage valid still clears.

Decomposition:
- Shared package approx_mul_pkg:
  - mode encoding constants MODE_EXACT = 2'b00, MODE_OR = 2'b01, MODE_TRUNC = 2'b10;
  - a function for mask M.
- One combinational sub-module approx_pair_compress:
  - parameters W, APPROX_COLS, K (pair index);
  - inputs x pair bits, y, mode;
  - output P_k (2W bits).
- It is instantiated W/2 times in a generate loop. The top level holds the pipeline registers and the adder.

Test Plan:
- Reset/idle: assert rst for 3 cycles, release -> out_valid = 0, out_p = 0, in_ready = 1. Then one beat x = 3, y = 3, mode 00 -> out_p = 9, out_mode = 00, exactly 2 cycles after accept.
- Mode sweep at W = 8, APPROX_COLS = 4, x = y = 255 (one beat per cycle):
  - mode 00 -> 65025;
  - mode 01 -> 65003;
  - mode 10 -> 64976;
  - mode 11 -> 65025 with out_mode = 11.
- Small operands in OR mode: x = 3, y = 3 -> 7; x = 3, y = 1 -> 3. Truncate mode: x = 3, y = 3 -> 0.
- Backpressure:
  - stream 5 beats back-to-back, hold out_ready = 0 for 4 cycles after the first result;
  - -> in_ready = 0 during the stall, out_p stable, no beat lost or duplicated, results in order after release.
- Async reset while 2 beats are in flight -> out_valid drops without a clock edge; no stale result after release.
- Random 10k beats, all modes, W = 8 and W = 12, APPROX_COLS in {0, 4, 7} -> match the reference formula. Approx ≤ exact; APPROX_COLS = 0 gives exact.

Source files
------------

// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate pipelined multiplier.
// Mode encodings and the low-column approximation mask.
package approx_mul_pkg;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_OR    = 2'b01;
  localparam logic [1:0] MODE_TRUNC = 2'b10;

  // Ones in product columns 0..cols-1.
  function automatic logic [31:0] approx_mask(input int cols);
    return (32'd1 << cols) - 32'd1;
  endfunction

endpackage

// File: rtl/approx_pair_compress.sv
// Compresses partial-product rows 2K and 2K+1 into one value.
// High columns are exact; low columns are OR-ed or dropped by mode.
import approx_mul_pkg::*;

module approx_pair_compress #(
  parameter int W           = 8,
  parameter int APPROX_COLS = 4,
  parameter int K           = 0
) (
  input  logic [1:0]     x_pair,
  input  logic [W-1:0]   y,
  input  logic [1:0]     mode,
  output logic [2*W-1:0] p
);

  localparam int PW = 2 * W;
  localparam logic [31:0] M32 = approx_mask(APPROX_COLS);
  localparam logic [PW-1:0] M = M32[PW-1:0];

  logic [PW-1:0] ye;
  logic [PW-1:0] a;
  logic [PW-1:0] b;

  assign ye = {{W{1'b0}}, y};
  assign a  = x_pair[0] ? (ye << (2 * K)) : '0;
  assign b  = x_pair[1] ? (ye << (2 * K + 1)) : '0;

  // Select pair sum by mode; reserved mode falls back to exact.
  always_comb begin
    p = a + b;
    unique case (1'b1)
      (mode == MODE_OR):
        p = ((a & M) | (b & M)) + (a & ~M) + (b & ~M);
      (mode == MODE_TRUNC):
        p = (a & ~M) + (b & ~M);
      default:
        p = a + b;
    endcase
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Two-stage pipelined W x W approximate multiplier.
// Stage 1 holds pair results; stage 2 holds their sum.
import approx_mul_pkg::*;

module approx_mul_pipe #(
  parameter int W           = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic [1:0]     out_mode
);

  localparam int NP = W / 2;

  logic                     en;
  logic [NP-1:0][2*W-1:0]   pair_p;
  logic [NP-1:0][2*W-1:0]   s1_p;
  logic [1:0]               s1_mode;
  logic                     s1_v;
  logic [2*W-1:0]           sum;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NP; k++) begin : g_pair
    approx_pair_compress #(
      .W           (W),
      .APPROX_COLS (APPROX_COLS),
      .K           (k)
    ) u_pair (
      .x_pair (in_x[2*k+1:2*k]),
      .y      (in_y),
      .mode   (in_mode),
      .p      (pair_p[k])
    );
  end

  // Stage 1: capture pair results, mode and beat valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_p    <= '0;
      s1_mode <= '0;
      s1_v    <= 1'b0;
    end else if (en) begin
      s1_p    <= pair_p;
      s1_mode <= in_mode;
      s1_v    <= in_valid;
    end
  end

  // Sum of all pair results, wrapping at 2W bits.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NP; i++) begin
      sum = sum + s1_p[i];
    end
  end

  // Stage 2: register product, mode and output valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p     <= '0;
      out_mode  <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_p     <= sum;
      out_mode  <= s1_mode;
      out_valid <= s1_v;
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe.
// Five configurations run in lockstep against a formula model.
module tb_approx_mul_pipe;

  typedef struct {
    longint     p;
    longint     exact;
    logic [1:0] mode;
  } exp_t;

  localparam int ND = 5;
  int ww[ND] = '{8, 8, 8, 12, 12};
  int ac[ND] = '{4, 0, 7, 4, 7};

  logic clk;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [1:0] in_mode;
  logic [7:0] x8, y8;
  logic [11:0] x12, y12;

  logic [ND-1:0] ov;
  logic [ND-1:0] ir;
  logic [15:0] p0, p1, p2;
  logic [23:0] p3, p4;
  logic [1:0] m0, m1, m2, m3, m4;

  int vectors = 0;
  int miscompares = 0;

  exp_t sq[ND][$];

  approx_mul_pipe #(.W(8), .APPROX_COLS(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_x(x8), .in_y(y8), .in_mode(in_mode), .out_valid(ov[0]),
    .out_ready(out_ready), .out_p(p0), .out_mode(m0));
  approx_mul_pipe #(.W(8), .APPROX_COLS(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_x(x8), .in_y(y8), .in_mode(in_mode), .out_valid(ov[1]),
    .out_ready(out_ready), .out_p(p1), .out_mode(m1));
  approx_mul_pipe #(.W(8), .APPROX_COLS(7)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_x(x8), .in_y(y8), .in_mode(in_mode), .out_valid(ov[2]),
    .out_ready(out_ready), .out_p(p2), .out_mode(m2));
  approx_mul_pipe #(.W(12), .APPROX_COLS(4)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
    .in_x(x12), .in_y(y12), .in_mode(in_mode), .out_valid(ov[3]),
    .out_ready(out_ready), .out_p(p3), .out_mode(m3));
  approx_mul_pipe #(.W(12), .APPROX_COLS(7)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]),
    .in_x(x12), .in_y(y12), .in_mode(in_mode), .out_valid(ov[4]),
    .out_ready(out_ready), .out_p(p4), .out_mode(m4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Product from the row-pair rules, using plain integer arithmetic.
  function automatic longint ref_p(int w, int cols, longint x, longint y,
                                   logic [1:0] mode);
    longint m, full, sum, a, b, pk;
    full = (64'd1 << (2 * w)) - 1;
    m    = (64'd1 << cols) - 1;
    sum  = 0;
    for (int k = 0; k < w / 2; k++) begin
      a = ((x >> (2 * k)) & 1) != 0 ? (y << (2 * k)) : 0;
      b = ((x >> (2 * k + 1)) & 1) != 0 ? (y << (2 * k + 1)) : 0;
      case (mode)
        2'b01:   pk = ((a & m) | (b & m)) + (a & ~m) + (b & ~m);
        2'b10:   pk = (a & ~m) + (b & ~m);
        default: pk = a + b;
      endcase
      sum = sum + pk;
    end
    return sum & full;
  endfunction

  function automatic longint pget(int d);
    case (d)
      0: return longint'(p0);
      1: return longint'(p1);
      2: return longint'(p2);
      3: return longint'(p3);
      default: return longint'(p4);
    endcase
  endfunction

  function automatic logic [1:0] mget(int d);
    case (d)
      0: return m0;
      1: return m1;
      2: return m2;
      3: return m3;
      default: return m4;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_mode = 2'b00;
    x8 = '0; y8 = '0; x12 = '0; y12 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (ov !== '0 || p0 !== '0 || m0 !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state: ov=%b p=%0d mode=%b want ov=0 p=0 mode=0",
               ov, p0, m0);
    end
    vectors++;
    if (ir !== '1) begin
      miscompares++;
      $display("FAIL reset_ready: in_ready=%b want all 1", ir);
    end
    x8 = 8'd3; y8 = 8'd3; x12 = 12'd3; y12 = 12'd3;
    in_mode = 2'b00;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (ov[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: out_valid=%b want 0", ov[0]);
    end
    @(negedge clk);
    vectors++;
    if (ov[0] !== 1'b1 || p0 !== 16'd9 || m0 !== 2'b00) begin
      miscompares++;
      $display("FAIL first_beat: v=%b p=%0d mode=%b want v=1 p=9 mode=00",
               ov[0], p0, m0);
    end
    vectors++;
    if (ov[3] !== 1'b1 || p3 !== 24'd9) begin
      miscompares++;
      $display("FAIL first_beat_w12: v=%b p=%0d want v=1 p=9", ov[3], p3);
    end
  endtask

  task automatic test_mode_sweep();
    int want[4] = '{65025, 65003, 64976, 65025};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        vectors++;
        if (ov[0] !== 1'b1 || longint'(p0) != want[i-2] ||
            m0 !== 2'(i - 2)) begin
          miscompares++;
          $display("FAIL mode_sweep_%0d: v=%b p=%0d mode=%b want v=1 p=%0d mode=%0d",
                   i - 2, ov[0], p0, m0, want[i-2], i - 2);
        end
        vectors++;
        if (p1 !== 16'd65025) begin
          miscompares++;
          $display("FAIL mode_sweep_ac0_%0d: p=%0d want 65025", i - 2, p1);
        end
      end
      if (i < 4) begin
        in_valid = 1'b1;
        x8 = 8'hff; y8 = 8'hff;
        in_mode = 2'(i);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_or_trunc_small();
    logic [7:0] tx[3] = '{8'd3, 8'd3, 8'd3};
    logic [7:0] ty[3] = '{8'd3, 8'd1, 8'd3};
    logic [1:0] tm[3] = '{2'b01, 2'b01, 2'b10};
    int want[3] = '{7, 3, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        vectors++;
        if (ov[0] !== 1'b1 || longint'(p0) != want[i-2]) begin
          miscompares++;
          $display("FAIL small_%0d: v=%b p=%0d want v=1 p=%0d",
                   i - 2, ov[0], p0, want[i-2]);
        end
      end
      if (i < 3) begin
        in_valid = 1'b1;
        x8 = tx[i]; y8 = ty[i]; in_mode = tm[i];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    logic [7:0] bx[5];
    logic [7:0] by[5];
    logic [1:0] bm[5];
    int sent = 0;
    int got = 0;
    int stall_left = 0;
    bit stalled_once = 0;
    bit was_stalled = 0;
    logic [15:0] prev_p = '0;
    int cyc = 0;
    for (int i = 0; i < 5; i++) begin
      bx[i] = 8'($urandom);
      by[i] = 8'($urandom);
      bm[i] = 2'($urandom_range(0, 2));
    end
    while (got < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ov[0] && !stalled_once) begin
        stalled_once = 1;
        stall_left = 4;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      in_valid = (sent < 5);
      if (sent < 5) begin
        x8 = bx[sent]; y8 = by[sent]; in_mode = bm[sent];
      end
      #1;
      if (ov[0] && !out_ready) begin
        vectors++;
        if (ir[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_ready: in_ready=%b want 0 during stall", ir[0]);
        end
        if (was_stalled) begin
          vectors++;
          if (p0 !== prev_p) begin
            miscompares++;
            $display("FAIL bp_stable: p=%0d want %0d", p0, prev_p);
          end
        end
      end
      was_stalled = ov[0] && !out_ready;
      prev_p = p0;
      if (ov[0] && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra: p=%0d with no beat pending, want none", p0);
        end else begin
          e = q.pop_front();
          got++;
          if (longint'(p0) != e.p) begin
            miscompares++;
            $display("FAIL bp_data_%0d: p=%0d want %0d", got, p0, e.p);
          end
        end
      end
      if (in_valid && ir[0]) begin
        e.p = ref_p(8, 4, bx[sent], by[sent], bm[sent]);
        e.exact = 0;
        e.mode = bm[sent];
        q.push_back(e);
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 5 || sent != 5 || stall_left != 0) begin
      miscompares++;
      $display("FAIL bp_count: got=%0d sent=%0d want 5 and 5", got, sent);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; x8 = 8'd17; y8 = 8'd23; in_mode = 2'b00;
    @(negedge clk);
    x8 = 8'd5; y8 = 8'd6;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (ov[0] !== 1'b1 || p0 !== 16'd391) begin
      miscompares++;
      $display("FAIL ar_inflight: v=%b p=%0d want v=1 p=391", ov[0], p0);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (ov !== '0 || p0 !== '0) begin
      miscompares++;
      $display("FAIL ar_async_drop: ov=%b p=%0d want ov=0 p=0", ov, p0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (ov !== '0 || ir !== '1) begin
        miscompares++;
        $display("FAIL ar_stale_%0d: ov=%b ir=%b want ov=0 ir=all1",
                 i, ov, ir);
      end
    end
  endtask

  function automatic bit any_pending();
    for (int d = 0; d < ND; d++) if (sq[d].size() != 0) return 1;
    return 0;
  endfunction

  task automatic test_random();
    int beats = 0;
    int cyc = 0;
    bit pend = 0;
    exp_t e;
    longint gp;
    longint xv, yv;
    for (int d = 0; d < ND; d++) sq[d].delete();
    while ((beats < 10000 || any_pending()) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (!pend) begin
        x8 = 8'($urandom); y8 = 8'($urandom);
        x12 = 12'($urandom); y12 = 12'($urandom);
        in_mode = 2'($urandom_range(0, 3));
        in_valid = (beats < 10000) && ($urandom_range(0, 4) != 0);
        pend = in_valid;
      end
      out_ready = ($urandom_range(0, 4) != 0);
      #1;
      for (int d = 0; d < ND; d++) begin
        if (ov[d] && out_ready) begin
          vectors++;
          if (sq[d].size() == 0) begin
            miscompares++;
            $display("FAIL rnd_spurious_d%0d: p=%0d with empty queue, want none",
                     d, pget(d));
          end else begin
            e = sq[d].pop_front();
            gp = pget(d);
            if (gp != e.p || mget(d) !== e.mode) begin
              miscompares++;
              $display("FAIL rnd_d%0d: p=%0d mode=%b want p=%0d mode=%b",
                       d, gp, mget(d), e.p, e.mode);
            end
            vectors++;
            if (gp > e.exact || (ac[d] == 0 && gp != e.exact)) begin
              miscompares++;
              $display("FAIL rnd_bound_d%0d: p=%0d exact=%0d want <= (== at cols 0)",
                       d, gp, e.exact);
            end
          end
        end
      end
      if (in_valid && ir[0]) begin
        for (int d = 0; d < ND; d++) begin
          xv = (ww[d] == 8) ? longint'(x8) : longint'(x12);
          yv = (ww[d] == 8) ? longint'(y8) : longint'(y12);
          e.p = ref_p(ww[d], ac[d], xv, yv, in_mode);
          e.exact = xv * yv;
          e.mode = in_mode;
          sq[d].push_back(e);
        end
        beats++;
        pend = 0;
      end
    end
    vectors++;
    if (cyc >= 40000) begin
      miscompares++;
      $display("FAIL rnd_timeout: beats=%0d after %0d cycles, want 10000 drained",
               beats, cyc);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode_sweep();
    test_or_trunc_small();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
